// File: rtl/v_cu_pkg.sv
// ============================================================
//  v_cu_pkg : shared vector-control-unit types and helpers
//  Revision : 1.0
// ============================================================
`default_nettype none

package v_cu_pkg;

  localparam int VREG_NUM = 32;

  typedef logic [4:0] vreg_idx_t;
  typedef logic [2:0] emul_t;

  // Register group base..base+2^emul-1; indices past the register file are dropped.
  function automatic logic [VREG_NUM-1:0] group_mask(input vreg_idx_t base, input emul_t emul);
    logic [VREG_NUM-1:0] m;
    int                  lo;
    int                  hi;
    m  = '0;
    lo = int'(base);
    hi = lo + (1 << int'(emul));
    for (int i = 0; i < VREG_NUM; i++) begin
      if (i >= lo && i < hi) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vreg_group_mask.sv
// ============================================================
//  vreg_group_mask : register-group mask for one operand
//  Revision : 1.0
// ============================================================
`default_nettype none

module vreg_group_mask
  import v_cu_pkg::*;
(
  input  logic                en_i,
  input  logic [4:0]          base_i,
  input  logic [2:0]          emul_i,
  output logic [VREG_NUM-1:0] mask_o
);

  assign mask_o = en_i ? group_mask(vreg_idx_t'(base_i), emul_t'(emul_i)) : '0;

endmodule

`default_nettype wire

// File: rtl/v_hazard_scoreboard.sv
// ============================================================
//  v_hazard_scoreboard : per-register busy/owner tracking and
//  per-write-port dependency detection for decode
//  Revision : 1.0
// ============================================================
`default_nettype none

module v_hazard_scoreboard #(
  parameter int W_PORTS_NUM = 4,
  parameter int VREG_NUM    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_vld_i,
  input  logic [4:0]             vd_i,
  input  logic [4:0]             vs1_i,
  input  logic [4:0]             vs2_i,
  input  logic [4:0]             vs3_i,
  input  logic                   vd_use_i,
  input  logic                   vs1_use_i,
  input  logic                   vs2_use_i,
  input  logic                   vs3_use_i,
  input  logic                   vm_use_i,
  input  logic [2:0]             emul_i,
  input  logic                   cfg_i,
  input  logic [W_PORTS_NUM-1:0] alloc_i,
  input  logic [W_PORTS_NUM-1:0] port_done_i,
  output logic [W_PORTS_NUM-1:0] dependancy_issue_o,
  output logic [VREG_NUM-1:0]    busy_o,
  output logic [31:0]            stall_cnt_o
);

  import v_cu_pkg::*;

  localparam int        OW     = (W_PORTS_NUM > 1) ? $clog2(W_PORTS_NUM) : 1;
  localparam vreg_idx_t VM_REG = '0;
  localparam emul_t     VM_EMUL = '0;

  logic [VREG_NUM-1:0] vd_mask, vs1_mask, vs2_mask, vs3_mask, vm_mask;
  logic [VREG_NUM-1:0] rd_mask;
  logic [VREG_NUM-1:0] busy_q, busy_d;
  logic [OW-1:0]       owner_q [VREG_NUM];
  logic [OW-1:0]       owner_d [VREG_NUM];
  logic [31:0]         stall_cnt_q, stall_cnt_d;
  logic [W_PORTS_NUM-1:0] hazard;
  logic [OW-1:0]       alloc_idx;
  logic                commit_en;
  logic                stall;

  vreg_group_mask u_vd_mask  (.en_i(vd_use_i),  .base_i(vd_i),   .emul_i(emul_i),  .mask_o(vd_mask));
  vreg_group_mask u_vs1_mask (.en_i(vs1_use_i), .base_i(vs1_i),  .emul_i(emul_i),  .mask_o(vs1_mask));
  vreg_group_mask u_vs2_mask (.en_i(vs2_use_i), .base_i(vs2_i),  .emul_i(emul_i),  .mask_o(vs2_mask));
  vreg_group_mask u_vs3_mask (.en_i(vs3_use_i), .base_i(vs3_i),  .emul_i(emul_i),  .mask_o(vs3_mask));
  vreg_group_mask u_vm_mask  (.en_i(vm_use_i),  .base_i(VM_REG), .emul_i(VM_EMUL), .mask_o(vm_mask));

  assign rd_mask = vs1_mask | vs2_mask | vs3_mask | vm_mask;

  // A config instruction waits for every port that still owns anything.
  always_comb begin
    hazard = '0;
    for (int p = 0; p < W_PORTS_NUM; p++) begin
      for (int r = 0; r < VREG_NUM; r++) begin
        if (busy_q[r] && owner_q[r] == OW'(p) && (cfg_i || rd_mask[r] || vd_mask[r]))
          hazard[p] = 1'b1;
      end
    end
  end

  assign dependancy_issue_o = instr_vld_i ? hazard : '0;

  always_comb begin
    alloc_idx = '0;
    for (int p = W_PORTS_NUM - 1; p >= 0; p--) begin
      if (alloc_i[p]) alloc_idx = OW'(p);
    end
  end

  assign commit_en = (|alloc_i) && instr_vld_i && vd_use_i;

  // Retire first so that a commit to the same register in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < VREG_NUM; r++) begin
      owner_d[r] = owner_q[r];
      if (port_done_i[owner_q[r]]) busy_d[r] = 1'b0;
      if (commit_en && vd_mask[r]) begin
        busy_d[r]  = 1'b1;
        owner_d[r] = alloc_idx;
      end
    end
  end

  assign stall       = instr_vld_i && (|dependancy_issue_o);
  assign stall_cnt_d = (stall && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
      for (int r = 0; r < VREG_NUM; r++) owner_q[r] <= '0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      for (int r = 0; r < VREG_NUM; r++) owner_q[r] <= owner_d[r];
    end
  end

  assign busy_o      = busy_q;
  assign stall_cnt_o = stall_cnt_q;

  // A port retiring this cycle may be re-allocated, so its own conflict is not an error.
  a_alloc_no_hazard : assert property (@(posedge clk) disable iff (rst)
    !((|alloc_i) && (|(dependancy_issue_o & ~port_done_i))));

endmodule

`default_nettype wire
